// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALUop;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, a, b, ALUop,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b, ALUop,
    output busy, done, result
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, signed/unsigned,
// returning quotient or remainder with a fixed WIDTH+1 cycle latency.
//
// state  | meaning
// S_IDLE | waiting for start; result held
// S_CALC | one restoring step per edge, counter 0..WIDTH-1
// S_FIN  | sign fix-up, result load, done pulse
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] quo_q,     quo_d;
  logic [WIDTH-1:0] rem_q,     rem_d;
  logic [WIDTH-1:0] dvs_q,     dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             rem_sel_q, rem_sel_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [WIDTH-1:0] result_q,  result_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic             sgn_mode;
  logic             unused_aluop_hi;

  assign unused_aluop_hi = ^bus.ALUop[3:2];
  assign sgn_mode        = bus.ALUop[0];

  // Shifted partial remainder can reach WIDTH+1 bits; its top bit alone proves it exceeds the divisor.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign fits      = rem_shift[WIDTH] | ~trial[WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_sel_d = rem_sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          quo_d     = (sgn_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
          dvs_d     = (sgn_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
          rem_d     = '0;
          cnt_d     = '0;
          // Divide by zero keeps the all-ones quotient; negating |a| restores the raw dividend.
          neg_quo_d = sgn_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) && (bus.b != '0);
          neg_rem_d = sgn_mode && bus.a[WIDTH-1];
          rem_sel_d = bus.ALUop[1];
          busy_d    = 1'b1;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = fits ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        if (rem_sel_q) begin
          result_d = neg_rem_q ? -rem_q : rem_q;
        end else begin
          result_d = neg_quo_q ? -quo_q : quo_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_sel_q <= rem_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle integer divide unit beside the single-cycle add/sub arithmetic part of the ALU.
- Add/sub completes combinationally; divide iterates one quotient bit per clock, using a shift-subtract restoring scheme.
- Uses a start/busy/done handshake so the datapath can stall on long operations.
- Returns either the quotient or the remainder, signed or unsigned, as selected by the same 4-bit ALUop encoding the arithmetic part consumes.

Parameters:
WIDTH, 32, operand and result width in bits; the iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only when not busy
a  input  WIDTH  dividend
b  input  WIDTH  divisor
ALUop  input  4  bit0: 1 = signed, 0 = unsigned; bit1: 1 = return remainder, 0 = return quotient; bits 3:2 ignored
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  quotient or remainder, held until next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE; busy = 0; done = 0; result = 0; all internal registers = 0.
- Reset mid-operation: aborts immediately. No done is produced, and result reads 0 after reset.
- States:
  - IDLE: waiting for a request.
  - CALC: iteration counter runs 0..WIDTH-1.
  - FIN: sign fix-up and result register load.
- Acceptance: start=1 at a rising edge while in IDLE. This also holds in the cycle where done is high, since state is back to IDLE by then.
- Capture on acceptance:
  - a, b and ALUop[1:0] are latched.
  - In signed mode, |a| and |b| are computed and the result signs are recorded: quotient sign = a[MSB] xor b[MSB]; remainder sign = a[MSB].
  - Partial remainder is cleared, the counter is cleared, and the unit enters CALC with busy=1.
- start while busy=1 is ignored. Operand changes during CALC have no effect.
- CALC step, one per edge:
  - Shift {remainder, quotient} left by 1.
  - Trial subtract divisor from the upper half. If non-negative, keep the difference and set the quotient LSB.
  - Use a WIDTH+1 bit subtractor so the borrow is explicit.
  - After WIDTH steps, go to FIN.
- FIN edge:
  - Negate quotient and/or remainder per the recorded signs.
  - Load result with the quotient or remainder per the latched ALUop[1].
  - Set done=1 and busy=0, then return to IDLE.
  - done drops at the next edge.
- Latency: with start sampled at edge 0, busy is high from edge 0 to edge WIDTH+1. done and result are valid from edge WIDTH+1 (edge 33 for WIDTH=32), with done high for exactly one cycle. Latency is fixed for all operand values.
- Rounding: signed division truncates toward zero. The remainder takes the sign of the dividend and satisfies a = q*b + r.
- Divide by zero (b=0):
  - Quotient = all ones.
  - Remainder = a, unmodified, in both modes.
  - Same fixed latency; no sign fix-up is applied.
- Signed overflow, a = most-negative and b = -1: quotient = most-negative (0x80000000), remainder = 0.
- result is unchanged between done pulses and is not cleared by a new start until FIN.

Test Plan:
- Reset and unsigned quotient:
  - Stimulus: reset low mid-idle; release; start with a=100, b=7, ALUop=4'b0000.
  - Response: busy high for 33 edges; done pulses once at edge 33; result=14.
- Signed remainder and quotient, same edge timing:
  - a=-7 (0xFFFFFFF9), b=2, ALUop=4'b0011: result=0xFFFFFFFF (-1).
  - Repeat with ALUop=4'b0001: result=0xFFFFFFFD (-3).
- Divide by zero:
  - a=0x12345678, b=0, quotient mode: result=0xFFFFFFFF.
  - Same operands, remainder mode: result=0x12345678.
  - Fixed latency in both cases.
- Signed overflow:
  - a=0x80000000, b=0xFFFFFFFF, ALUop=4'b0001: result=0x80000000.
  - Same operands, ALUop=4'b0011: result=0.
- Handshake:
  - Pulse start again at edge 10 with different operands: ignored; first result (100/7=14) still returned.
  - Issue start in the done cycle: accepted back-to-back, next done exactly 33 edges later.
- Reset mid-operation:
  - Assert rst_n low at edge 15 of a divide: busy, done and result go to 0 asynchronously; no done pulse follows.
  - After release, a new 100/7 completes normally.
